pixel_frame_arbiter: RTL and testbench
======================================

// Module: pixel_frame_arbiter
// PURPOSE
//  Shares one downstream pixel stream between two upstream pixel sources at frame granularity.
//  Locks onto a source at its frame start (row 0, col 0) and forwards only that source until its last pixel.
//  Releases at the last pixel or on a silence timeout, then re-arbitrates round-robin.
//  Streams carry no backpressure, so pixels from the non-granted source are discarded.
// PARAMETERS
//  FP_M     8     integer bits of pixel fixed-point format
//  FP_N     0     fractional bits of pixel fixed-point format
//  FP_S     0     sign bits (0 or 1); PW = FP_M+FP_N+FP_S
//  WIDTH    640   frame width in pixels; last col = WIDTH-1
//  HEIGHT   480   frame height in rows; last row = HEIGHT-1
//  TIMEOUT  4096  idle cycles while locked before forced release; >= 2
// PORTS
//  clk             in   1   clock
//  rst_n           in   1   synchronous reset, active low
//  enable          in   1   1 = new locks allowed; 0 = finish current frame, then stay idle
//  s0_pixel        in   PW  source 0 pixel
//  s0_valid        in   1   source 0 valid
//  s0_row/s0_col   in   16  source 0 coordinates
//  s1_pixel/s1_valid/s1_row/s1_col   in   PW/1/16/16   source 1, same meaning
//  m_pixel         out  PW  forwarded pixel
//  m_valid         out  1   forwarded valid
//  m_row/m_col     out  16  forwarded coordinates
//  grant           out  2   one-hot owner: 01 = s0, 10 = s1, 00 = none
//  frame_done      out  1   1-cycle pulse when the owner's last pixel is forwarded
//  timeout         out  1   1-cycle pulse on forced release
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; rr_ptr = 0 (s0 preferred first); idle counter = 0.
//  start_k = sk_valid & row==0 & col==0.
//  last_k  = sk_valid & row==HEIGHT-1 & col==WIDTH-1.
//  FSM states: IDLE, LOCK0, LOCK1.
//   IDLE: enable & start_k -> LOCKk. If both start in the same cycle, the rr_ptr source wins.
//         The start pixel itself is forwarded.
//   LOCKk: forward sk beats only; other source dropped.
//         last_k -> IDLE, frame_done pulse, rr_ptr = other source.
//         start_k while locked (owner restarts frame) -> stay LOCKk, forward it, counter cleared.
//   LOCKk: TIMEOUT consecutive cycles with sk_valid=0 -> IDLE, timeout pulse, rr_ptr = other source.
//   A frame that is both start and last (WIDTH=HEIGHT=1) locks and releases in the same cycle.
//  Latency: outputs registered, exactly 1 cycle from input beat to m_* beat.
//   grant is updated in the same cycle as the first forwarded m_valid.
//   grant returns to 00 in the cycle after the release beat.
//  m_pixel/row/col hold their last value when m_valid=0. No X propagation: unused inputs are never
//   sampled into outputs.
//  Non-start pixels arriving in IDLE are dropped (mid-frame join not allowed).
//  enable deassert mid-frame does not abort the frame; it blocks only the next lock.
//  rst_n low mid-frame: next cycle all outputs 0, frame abandoned, no frame_done.
//  Idle counter saturates at TIMEOUT; width = $clog2(TIMEOUT+1).
// CONFIGURATION
//  PFA_DROP_COUNT_EN defined:
//   adds output ports drop_cnt0 and drop_cnt1 (out, 32 bits each).
//   Each counts valid beats from that source that were not forwarded.
//   Counters saturate at 2^32-1 and are reset to 0 by rst_n.
//  PFA_DROP_COUNT_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1. WIDTH=4, HEIGHT=2; s0 sends full frame, s1 silent ->
//     8 m_valid beats, each 1 cycle later; grant=01; frame_done pulses with row 1, col 3.
//  2. s0 and s1 both start in the same cycle after reset ->
//     s0 wins; next simultaneous start -> s1 wins (round-robin).
//  3. s1 streams mid-frame while s0 locked ->
//     no s1 beat on m_*; drop_cnt1 increments per beat when PFA_DROP_COUNT_EN is defined.
//  4. TIMEOUT=8; s0 stops after 3 pixels ->
//     timeout pulse 8 cycles after its last valid; grant=00; s1 start is then accepted.
//  5. enable=0 mid-frame of s0 ->
//     frame completes with frame_done; later starts ignored; grant stays 00.
//  6. rst_n low for 1 cycle mid-frame ->
//     all outputs 0 next cycle; s0 non-start pixels afterwards dropped until its next (0,0).

Source files
------------

// File: rtl/pixel_frame_arbiter.sv
// -----------------------------------------------------------------------------
// pixel_frame_arbiter
//
// Shares one downstream pixel stream between two upstream pixel sources at
// frame granularity. The arbiter locks onto a source when that source presents
// its frame-start pixel (row 0, col 0). From then on it forwards only that
// source until the source's last pixel (row HEIGHT-1, col WIDTH-1), or until
// the source has been silent for TIMEOUT consecutive cycles. After a release
// the other source is preferred for the next lock (round-robin). The streams
// carry no backpressure, so beats from the source that is not forwarded are
// discarded.
//
// Ports
//   clk                      clock
//   rst_n                    synchronous reset, active low
//   enable                   1 = new locks allowed; 0 = finish the current
//                            frame, then stay idle
//   s0_pixel/valid/row/col   source 0 beat (pixel width PW, 16-bit coords)
//   s1_pixel/valid/row/col   source 1 beat
//   m_pixel/valid/row/col    forwarded beat, one cycle after the input beat;
//                            pixel/row/col hold while m_valid is 0
//   grant                    one-hot owner: 01 = s0, 10 = s1, 00 = none
//   frame_done               one-cycle pulse with the owner's last pixel
//   timeout                  one-cycle pulse on a forced (silence) release
//   drop_cnt0/drop_cnt1      saturating 32-bit counts of valid beats per
//                            source that were not forwarded; present only
//                            when PFA_DROP_COUNT_EN is defined
//
// Configuration macro
//   PFA_DROP_COUNT_EN        adds the drop counters and their output ports
//
// Pixel format: PW = FP_M + FP_N + FP_S bits (integer, fraction, sign). The
// arbiter only moves pixels, so the format affects nothing but the width.
// -----------------------------------------------------------------------------
module pixel_frame_arbiter #(
  parameter int FP_M    = 8,
  parameter int FP_N    = 0,
  parameter int FP_S    = 0,
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int TIMEOUT = 4096,
  localparam int PW     = FP_M + FP_N + FP_S
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic [PW-1:0] s0_pixel,
  input  logic          s0_valid,
  input  logic [15:0]   s0_row,
  input  logic [15:0]   s0_col,
  input  logic [PW-1:0] s1_pixel,
  input  logic          s1_valid,
  input  logic [15:0]   s1_row,
  input  logic [15:0]   s1_col,
  output logic [PW-1:0] m_pixel,
  output logic          m_valid,
  output logic [15:0]   m_row,
  output logic [15:0]   m_col,
  output logic [1:0]    grant,
  output logic          frame_done,
  output logic          timeout
`ifdef PFA_DROP_COUNT_EN
  ,
  output logic [31:0]   drop_cnt0,
  output logic [31:0]   drop_cnt1
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  // The idle counter must be able to hold TIMEOUT itself (saturation value).
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);
  localparam logic [15:0]   LAST_ROW = 16'(HEIGHT - 1);
  localparam logic [15:0]   LAST_COL = 16'(WIDTH - 1);

  state_t        state;
  logic          rr_ptr;     // source preferred on a simultaneous start
  logic [CW-1:0] idle_cnt;   // consecutive silent cycles of the owner

  // Frame boundary markers per source.
  logic start0, start1, last0, last1;

  assign start0 = s0_valid && (s0_row == 16'd0)     && (s0_col == 16'd0);
  assign start1 = s1_valid && (s1_row == 16'd0)     && (s1_col == 16'd0);
  assign last0  = s0_valid && (s0_row == LAST_ROW)  && (s0_col == LAST_COL);
  assign last1  = s1_valid && (s1_row == LAST_ROW)  && (s1_col == LAST_COL);

  // Per-cycle decision: which source (if any) is forwarded this cycle and
  // whether the lock ends on this cycle.
  logic          take;     // a beat is forwarded this cycle
  logic          sel;      // source index of the forwarded / owning source
  logic          done;     // forwarded beat is the owner's last pixel
  logic          expire;   // owner silent for TIMEOUT cycles
  logic [CW-1:0] cnt_inc;  // saturating increment of the idle counter

  // NOTE: every signal assigned in always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    take    = 1'b0;
    sel     = rr_ptr;
    done    = 1'b0;
    expire  = 1'b0;
    cnt_inc = (idle_cnt == TO_LIMIT) ? idle_cnt : idle_cnt + CW'(1);

    unique case (state)
      IDLE: begin
        if (enable && (start0 || start1)) begin
          take = 1'b1;
          // Simultaneous starts go to the round-robin favourite; otherwise
          // whichever source is starting wins.
          sel  = (start0 && start1) ? rr_ptr : start1;
        end
      end
      LOCK0: begin
        sel  = 1'b0;
        take = s0_valid;
      end
      LOCK1: begin
        sel  = 1'b1;
        take = s1_valid;
      end
      default: begin
        take = 1'b0;
      end
    endcase

    // A start pixel that is also the last pixel (1x1 frame) releases in the
    // same cycle it locks, so done is evaluated for IDLE takes as well.
    done   = take && (sel ? last1 : last0);
    expire = (state != IDLE) && !take && (cnt_inc == TO_LIMIT);
  end

  // NOTE: reset is synchronous (sampled only on the clock edge) and all
  // sequential state uses non-blocking assignments so every register sees
  // the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rr_ptr     <= 1'b0;
      idle_cnt   <= '0;
      m_pixel    <= '0;
      m_valid    <= 1'b0;
      m_row      <= '0;
      m_col      <= '0;
      grant      <= 2'b00;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      m_valid    <= take;
      frame_done <= done;
      timeout    <= expire;

      // Data registers load only on a forwarded beat, so the dropped source
      // never reaches the outputs and the last forwarded beat is held.
      if (take) begin
        m_pixel <= sel ? s1_pixel : s0_pixel;
        m_row   <= sel ? s1_row   : s0_row;
        m_col   <= sel ? s1_col   : s0_col;
      end

      // grant follows the owner: it rises with the first forwarded beat,
      // stays up through the release beat, and drops at once on a timeout.
      if ((take || (state != IDLE)) && !expire) begin
        grant <= {sel, ~sel};
      end else begin
        grant <= 2'b00;
      end

      if (done || expire) begin
        state    <= IDLE;
        rr_ptr   <= ~sel;
        idle_cnt <= '0;
      end else if (take) begin
        // Covers a new lock and an owner restarting its frame alike.
        state    <= sel ? LOCK1 : LOCK0;
        idle_cnt <= '0;
      end else if (state != IDLE) begin
        idle_cnt <= cnt_inc;
      end
    end
  end

`ifdef PFA_DROP_COUNT_EN
  // Any valid beat that is not the forwarded one is a drop: the loser of a
  // lock, a non-owner while locked, or any beat refused while idle.
  logic drop0, drop1;

  assign drop0 = s0_valid && !(take && !sel);
  assign drop1 = s1_valid && !(take &&  sel);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt0 <= '0;
      drop_cnt1 <= '0;
    end else begin
      if (drop0 && (drop_cnt0 != 32'hFFFF_FFFF)) begin
        drop_cnt0 <= drop_cnt0 + 32'd1;
      end
      if (drop1 && (drop_cnt1 != 32'hFFFF_FFFF)) begin
        drop_cnt1 <= drop_cnt1 + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pixel_frame_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pixel_frame_arbiter
//
// Directed bench for pixel_frame_arbiter with a 4x2 frame and TIMEOUT of 8.
// A frame-level model (owner / preferred source / silence count) predicts the
// outputs after every clock edge; a negedge process compares the DUT against
// it every cycle. Hand-computed literal checks pin the key scenarios.
// -----------------------------------------------------------------------------
module tb_pixel_frame_arbiter;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int TO = 8;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic [PW-1:0] s0_pixel, s1_pixel;
  logic          s0_valid, s1_valid;
  logic [15:0]   s0_row, s0_col, s1_row, s1_col;
  logic [PW-1:0] m_pixel;
  logic          m_valid;
  logic [15:0]   m_row, m_col;
  logic [1:0]    grant;
  logic          frame_done;
  logic          timeout;
`ifdef PFA_DROP_COUNT_EN
  logic [31:0]   drop_cnt0, drop_cnt1;
`endif

  always #5 clk = ~clk;

  pixel_frame_arbiter #(
    .FP_M(8), .FP_N(0), .FP_S(0),
    .WIDTH(W), .HEIGHT(H), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s0_pixel(s0_pixel), .s0_valid(s0_valid), .s0_row(s0_row), .s0_col(s0_col),
    .s1_pixel(s1_pixel), .s1_valid(s1_valid), .s1_row(s1_row), .s1_col(s1_col),
    .m_pixel(m_pixel), .m_valid(m_valid), .m_row(m_row), .m_col(m_col),
    .grant(grant), .frame_done(frame_done), .timeout(timeout)
`ifdef PFA_DROP_COUNT_EN
    , .drop_cnt0(drop_cnt0), .drop_cnt1(drop_cnt1)
`endif
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------- model
  int            owner  = -1;   // -1 = nobody holds the stream
  int            pref   = 0;    // source favoured on a simultaneous start
  int            silent = 0;    // silent cycles of the current owner
  bit            started = 1'b0;
  logic          exp_valid, exp_done, exp_to;
  logic [1:0]    exp_grant;
  logic [PW-1:0] exp_pix;
  logic [15:0]   exp_row, exp_col;
  longint        exp_drop [2];

  always @(posedge clk) begin : model
    bit            v  [2];
    bit            st [2];
    bit            ls [2];
    logic [15:0]   r  [2];
    logic [15:0]   c  [2];
    logic [PW-1:0] p  [2];
    int            fwd;
    cyc++;
    v[0] = s0_valid; r[0] = s0_row; c[0] = s0_col; p[0] = s0_pixel;
    v[1] = s1_valid; r[1] = s1_row; c[1] = s1_col; p[1] = s1_pixel;
    for (int k = 0; k < 2; k++) begin
      st[k] = v[k] && r[k] == 0 && c[k] == 0;
      ls[k] = v[k] && r[k] == H - 1 && c[k] == W - 1;
    end
    if (!rst_n) begin
      owner = -1; pref = 0; silent = 0;
      exp_valid = 0; exp_done = 0; exp_to = 0; exp_grant = 0;
      exp_pix = 0; exp_row = 0; exp_col = 0;
      exp_drop[0] = 0; exp_drop[1] = 0;
    end else begin
      fwd = -1; exp_valid = 0; exp_done = 0; exp_to = 0;
      if (owner < 0) begin
        if (enable) begin
          if (st[0] && st[1]) fwd = pref;
          else if (st[0])     fwd = 0;
          else if (st[1])     fwd = 1;
        end
        if (fwd >= 0) owner = fwd;
      end else if (v[owner]) begin
        fwd = owner;
      end

      if (fwd >= 0) begin
        exp_valid = 1; exp_pix = p[fwd]; exp_row = r[fwd]; exp_col = c[fwd];
        exp_grant = (fwd == 0) ? 2'b01 : 2'b10;
        silent = 0;
        if (ls[fwd]) begin
          exp_done = 1; pref = 1 - fwd; owner = -1;
        end
      end else if (owner >= 0) begin
        silent++;
        if (silent == TO) begin
          exp_to = 1; pref = 1 - owner; owner = -1; silent = 0; exp_grant = 0;
        end else begin
          exp_grant = (owner == 0) ? 2'b01 : 2'b10;
        end
      end else begin
        exp_grant = 0;
      end

      for (int k = 0; k < 2; k++)
        if (v[k] && fwd != k) exp_drop[k]++;
    end
    started = 1'b1;
  end

  // ------------------------------------------------- compare and monitor
  int mv_cnt = 0, fd_cnt = 0, to_cnt = 0, ee_cnt = 0;
  int last_mv_cyc = 0, to_cyc = 0;
  logic [15:0] fd_row, fd_col;
  logic [1:0]  fd_grant, to_grant;

  always @(negedge clk) begin
    if (started) begin
      check("m_valid",    m_valid,    exp_valid);
      check("grant",      grant,      exp_grant);
      check("frame_done", frame_done, exp_done);
      check("timeout",    timeout,    exp_to);
      check("m_pixel",    m_pixel,    exp_pix);
      check("m_row",      m_row,      exp_row);
      check("m_col",      m_col,      exp_col);
`ifdef PFA_DROP_COUNT_EN
      check("drop_cnt0",  drop_cnt0,  exp_drop[0]);
      check("drop_cnt1",  drop_cnt1,  exp_drop[1]);
`endif
      if (m_valid === 1'b1) begin
        mv_cnt++; last_mv_cyc = cyc;
        if (m_pixel === 8'hEE) ee_cnt++;
      end
      if (frame_done === 1'b1) begin
        fd_cnt++; fd_row = m_row; fd_col = m_col; fd_grant = grant;
      end
      if (timeout === 1'b1) begin
        to_cnt++; to_cyc = cyc; to_grant = grant;
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic step(input bit v0, input int r0, input int c0, input int p0,
                      input bit v1, input int r1, input int c1, input int p1);
    @(negedge clk);
    s0_valid = v0; s0_row = 16'(r0); s0_col = 16'(c0); s0_pixel = 8'(p0);
    s1_valid = v1; s1_row = 16'(r1); s1_col = 16'(c1); s1_pixel = 8'(p1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int mv0, fd0, to0;
`ifdef PFA_DROP_COUNT_EN
  longint d1_snap;
`endif

  initial begin
    rst_n = 1'b0; enable = 1'b1;
    s0_valid = 0; s0_row = 0; s0_col = 0; s0_pixel = 0;
    s1_valid = 0; s1_row = 0; s1_col = 0; s1_pixel = 0;
    repeat (2) @(negedge clk);
    check("reset_m_valid", m_valid, 1'b0);
    check("reset_grant",   grant,   2'b00);
    rst_n = 1'b1;

    // 1: s0 full frame, s1 silent.
    mv0 = mv_cnt; fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) begin
      step(1, i / 4, i % 4, i + 1, 0, 0, 0, 0);
      if (i == 1) begin
        check("t1_first_valid", m_valid, 1'b1);
        check("t1_first_pixel", m_pixel, 8'd1);
        check("t1_first_grant", grant,   2'b01);
      end
    end
    idle(3); #1;
    check("t1_beats",    mv_cnt - mv0, 8);
    check("t1_done_cnt", fd_cnt - fd0, 1);
    check("t1_done_row", fd_row,   16'd1);
    check("t1_done_col", fd_col,   16'd3);
    check("t1_done_grt", fd_grant, 2'b01);
    check("t1_grant_off", grant,   2'b00);

    // 2: simultaneous starts after reset, round-robin.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, i / 4, i % 4, 8'h10 + i, 1, i / 4, i % 4, 8'h80 + i);
      if (i == 1) begin
        check("t2_first_grant", grant,   2'b01);
        check("t2_first_pixel", m_pixel, 8'h10);
      end
    end
    idle(2);
`ifdef PFA_DROP_COUNT_EN
    #1 check("t2_drop1", drop_cnt1, 32'd8);
`endif
    for (int i = 0; i < 8; i++) begin
      step(1, i / 4, i % 4, 8'h10 + i, 1, i / 4, i % 4, 8'h80 + i);
      if (i == 1) begin
        check("t2_second_grant", grant,   2'b10);
        check("t2_second_pixel", m_pixel, 8'h80);
      end
    end
    idle(2);

    // 3: s1 streams mid-frame while s0 is locked.
    mv0 = mv_cnt;
`ifdef PFA_DROP_COUNT_EN
    #1 d1_snap = drop_cnt1;
`endif
    for (int i = 0; i < 8; i++) step(1, i / 4, i % 4, 8'h20 + i, 1, 1, 2, 8'hEE);
    idle(2); #1;
    check("t3_beats",   mv_cnt - mv0, 8);
    check("t3_no_s1",   ee_cnt, 0);
`ifdef PFA_DROP_COUNT_EN
    check("t3_drop1", drop_cnt1 - d1_snap, 32'd8);
`endif

    // 4: s0 stalls after 3 pixels -> timeout, then s1 accepted.
    do_reset();
    to0 = to_cnt;
    for (int i = 0; i < 3; i++) step(1, 0, i, i + 1, 0, 0, 0, 0);
    idle(12); #1;
    check("t4_to_cnt",   to_cnt - to0, 1);
    check("t4_to_delay", to_cyc - last_mv_cyc, 8);
    check("t4_to_grant", to_grant, 2'b00);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 1, i / 4, i % 4, 8'h40 + i);
      if (i == 1) check("t4_s1_grant", grant, 2'b10);
    end
    idle(2);

    // 5: enable dropped mid-frame.
    fd0 = fd_cnt;
    for (int i = 0; i < 8; i++) begin
      step(1, i / 4, i % 4, 8'h30 + i, 0, 0, 0, 0);
      if (i == 3) enable = 1'b0;
    end
    idle(2); #1;
    check("t5_done", fd_cnt - fd0, 1);
    mv0 = mv_cnt;
    step(1, 0, 0, 8'h31, 1, 0, 0, 8'h32);
    step(1, 0, 1, 8'h33, 0, 0, 0, 0);
    idle(3); #1;
    check("t5_no_beats", mv_cnt - mv0, 0);
    check("t5_grant",    grant, 2'b00);
    enable = 1'b1;

    // 6: reset mid-frame, then s0 must restart at (0,0).
    for (int i = 0; i < 3; i++) step(1, 0, i, 8'h50 + i, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    s0_valid = 1'b1; s0_row = 16'd0; s0_col = 16'd3; s0_pixel = 8'h53;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_rst_valid", m_valid,    1'b0);
    check("t6_rst_grant", grant,      2'b00);
    check("t6_rst_pixel", m_pixel,    8'h00);
    check("t6_rst_col",   m_col,      16'd0);
    check("t6_rst_done",  frame_done, 1'b0);
    mv0 = mv_cnt;
    for (int i = 0; i < 4; i++) step(1, 1, i, 8'h60 + i, 0, 0, 0, 0);
    idle(2); #1;
    check("t6_dropped", mv_cnt - mv0, 0);
    step(1, 0, 0, 8'h55, 0, 0, 0, 0);
    idle(1);
    check("t6_relock_valid", m_valid, 1'b1);
    check("t6_relock_pixel", m_pixel, 8'h55);
    check("t6_relock_grant", grant,   2'b01);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
